// File: rtl/mem_arbiter_if.sv
// Requester and memory-manager signal bundle for mem_arbiter.
// slave = arbiter side, master = requesters plus memory manager.
interface mem_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic [3:0]          req;
  logic [3:0]          wren;
  logic [4*ADDR_W-1:0] addr;
  logic [4*DATA_W-1:0] wdata;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                err;
  logic [1:0]          grant_id;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_wren;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_done;

  modport slave (
    input  req, wren, addr, wdata,
    input  mem_ready, mem_rdata, mem_done,
    output ack, rdata, err, grant_id,
    output mem_req, mem_wren, mem_addr, mem_wdata
  );

  modport master (
    output req, wren, addr, wdata,
    output mem_ready, mem_rdata, mem_done,
    input  ack, rdata, err, grant_id,
    input  mem_req, mem_wren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Four-way round-robin arbiter in front of the single-word DDR port.
// Define MEM_ARB_PRIORITY_EN to give requester 0 strict priority.
module mem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        ptr_q;
  logic [1:0]        gid_q;
  logic [1:0]        win;
  logic              win_vld;
  logic [3:0]        req_m;
  logic [1:0]        idx;
  logic [CW-1:0]     cnt_q;
  logic              tmo;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign tmo = (cnt_q == CW'(TIMEOUT));

  // First pending requester at or after ptr, wrapping
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    idx     = 2'd0;
    req_m   = bus.req;
`ifdef MEM_ARB_PRIORITY_EN
    if (bus.req[0]) begin
      win_vld = 1'b1;
    end
    req_m[0] = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!win_vld && req_m[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_ready && win_vld) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_done || tmo) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req = 1'b0;
    bus.ack     = 4'b0000;
    unique case (1'b1)
      state_q == BUSY: bus.mem_req = 1'b1;
      state_q == RESP: bus.ack = 4'b0001 << gid_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 2'd0;
      gid_q   <= 2'd0;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == BUSY) begin
        gid_q   <= win;
        wren_q  <= bus.wren[win];
        addr_q  <= bus.addr[win*ADDR_W +: ADDR_W];
        wdata_q <= bus.wdata[win*DATA_W +: DATA_W];
        cnt_q   <= '0;
      end
      if (state_q == BUSY) begin
        // Writes echo their own data, matching the memory manager
        if (bus.mem_done) begin
          rdata_q <= wren_q ? wdata_q : bus.mem_rdata;
        end else if (tmo) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
      if (state_q == RESP) begin
`ifdef MEM_ARB_PRIORITY_EN
        if (gid_q != 2'd0) begin
          ptr_q <= gid_q + 2'd1;
        end
`else
        ptr_q <= gid_q + 2'd1;
`endif
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.grant_id  = gid_q;
  assign bus.mem_wren  = wren_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction model.
// Honours MEM_ARB_PRIORITY_EN the same way the design does.
module tb_mem_arbiter;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked by phase
  int          m_phase;
  int          m_age;
  logic [1:0]  m_ptr;
  logic [1:0]  m_gid;
  logic        m_wren;
  logic        m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic [1:0]  m_win;

  function automatic logic [1:0] pick(input logic [3:0] r,
                                      input logic [1:0] p);
    logic [3:0] rr;
    rr = r;
`ifdef MEM_ARB_PRIORITY_EN
    if (rr[0]) return 2'd0;
    rr[0] = 1'b0;
`endif
    for (int k = 0; k < 4; k++)
      if (rr[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
    return 2'd0;
  endfunction

  assign m_win = pick(bus.req, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_age   <= 0;
      m_ptr   <= 2'd0;
      m_gid   <= 2'd0;
      m_wren  <= 1'b0;
      m_err   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.mem_ready && bus.req != 4'b0) begin
            m_gid   <= m_win;
            m_wren  <= bus.wren[m_win];
            m_addr  <= bus.addr[m_win*AW +: AW];
            m_wdata <= bus.wdata[m_win*DW +: DW];
            m_age   <= 0;
            m_phase <= 1;
          end
        end
        1: begin
          m_age <= m_age + 1;
          if (bus.mem_done) begin
            m_rdata <= m_wren ? m_wdata : bus.mem_rdata;
            m_phase <= 2;
          end else if (m_age + 1 == TO + 1) begin
            m_err   <= 1'b1;
            m_rdata <= '0;
            m_phase <= 2;
          end
        end
        default: begin
`ifdef MEM_ARB_PRIORITY_EN
          if (m_gid != 2'd0) m_ptr <= m_gid + 2'd1;
`else
          m_ptr <= m_gid + 2'd1;
`endif
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [3:0] ea;
    ea = (m_phase == 2) ? 4'(4'b0001 << m_gid) : 4'b0000;
    check("mem_req", 64'(bus.mem_req), 64'(m_phase == 1));
    check("ack", 64'(bus.ack), 64'(ea));
    if (m_phase == 2) check("rdata", 64'(bus.rdata), 64'(m_rdata));
    check("err", 64'(bus.err), 64'(m_err));
    check("grant_id", 64'(bus.grant_id), 64'(m_gid));
    check("mem_wren", 64'(bus.mem_wren), 64'(m_wren));
    check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
  end

  // Memory manager stand-in: 0 random delay, 1 immediate, 2 never
  int          mem_mode = 1;
  logic [DW-1:0] fixed_rd = '0;
  bit          in_txn = 1'b0;
  int          left = 0;

  task automatic mem_respond();
    bus.mem_done = 1'b0;
    if (mem_mode != 1) bus.mem_rdata = $urandom;
    if (bus.mem_req) begin
      if (mem_mode != 2) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          left = (mem_mode == 1) ? 0 : $urandom_range(0, 5);
        end
        if (left == 0) begin
          bus.mem_done = 1'b1;
          if (mem_mode == 1) bus.mem_rdata = fixed_rd;
          in_txn = 1'b0;
        end else begin
          left--;
        end
      end
    end else begin
      in_txn = 1'b0;
      if (mem_mode == 0) bus.mem_done = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_respond();
  endtask

  task automatic wait_sig(input string nm, input int which, input int maxc);
    bit got;
    got = 1'b0;
    for (int c = 0; c < maxc && !got; c++) begin
      tick();
      if (which == 0 && bus.mem_req) got = 1'b1;
      if (which == 1 && bus.ack != 4'b0) got = 1'b1;
    end
    check(nm, 64'(got), 64'(1));
  endtask

  task automatic do_reset();
    bus.req = 4'b0;
    bus.wren = 4'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic new_fields(input int i);
    bus.wren[i] = 1'($urandom_range(0, 1));
    bus.addr[i*AW +: AW] = AW'($urandom);
    bus.wdata[i*DW +: DW] = $urandom;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < 4; i++) begin
      if (bus.req[i]) begin
        if (bus.ack[i]) begin
          if ($urandom_range(0, 1) == 1) bus.req[i] = 1'b0;
          else new_fields(i);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.req[i] = 1'b1;
        new_fields(i);
      end
    end
    bus.mem_ready = ($urandom_range(0, 9) != 0);
  endtask

  int fair_exp[8];
  int got_ids[8];

  initial begin
    int n;
    int c;
    bit prev;
    bit drained;
    bus.req = 4'b0;
    bus.wren = 4'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_done = 1'b0;
`ifdef MEM_ARB_PRIORITY_EN
    fair_exp = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    tick();
    tick();
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_ack", 64'(bus.ack), 64'(0));
    check("rst_err", 64'(bus.err), 64'(0));
    check("rst_grant", 64'(bus.grant_id), 64'(0));
    check("rst_rdata", 64'(bus.rdata), 64'(0));
    check("rst_addr", 64'(bus.mem_addr), 64'(0));
    rst_n = 1'b1;

    // Single read
    bus.mem_ready = 1'b1;
    mem_mode = 1;
    fixed_rd = 32'hDEADBEEF;
    bus.addr[1*AW +: AW] = 18'h00ABC;
    bus.req = 4'b0010;
    wait_sig("rd_grant_wait", 0, 20);
    check("rd_addr", 64'(bus.mem_addr), 64'(18'h00ABC));
    check("rd_wren", 64'(bus.mem_wren), 64'(0));
    check("rd_gid", 64'(bus.grant_id), 64'(1));
    wait_sig("rd_ack_wait", 1, 20);
    check("rd_ack", 64'(bus.ack), 64'(4'b0010));
    check("rd_data", 64'(bus.rdata), 64'(32'hDEADBEEF));
    bus.req = 4'b0;

    // Single write
    bus.wren = 4'b0100;
    bus.wdata[2*DW +: DW] = 32'h12345678;
    bus.req = 4'b0100;
    wait_sig("wr_grant_wait", 0, 20);
    check("wr_wren", 64'(bus.mem_wren), 64'(1));
    check("wr_wdata", 64'(bus.mem_wdata), 64'(32'h12345678));
    wait_sig("wr_ack_wait", 1, 20);
    check("wr_ack", 64'(bus.ack), 64'(4'b0100));
    check("wr_rdata", 64'(bus.rdata), 64'(32'h12345678));
    bus.req = 4'b0;
    bus.wren = 4'b0;

    // Fairness from ptr=0
    do_reset();
    bus.req = 4'b1111;
    n = 0;
    prev = 1'b0;
    for (int k = 0; k < 100 && n < 8; k++) begin
      tick();
      if (bus.mem_req && !prev) begin
        got_ids[n] = int'(bus.grant_id);
        n++;
      end
      prev = bus.mem_req;
    end
    bus.req = 4'b0;
    check("fair_count", 64'(n), 64'(8));
    for (int k = 0; k < n; k++)
      check($sformatf("fair_%0d", k), 64'(got_ids[k]), 64'(fair_exp[k]));
    tick();
    tick();
    tick();

    // Not ready blocks grants
    do_reset();
    bus.mem_ready = 1'b0;
    bus.req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("nr_mem_req", 64'(bus.mem_req), 64'(0));
    end
    bus.mem_ready = 1'b1;
    tick();
    check("nr_grant", 64'(bus.mem_req), 64'(1));
    check("nr_gid", 64'(bus.grant_id), 64'(0));
    wait_sig("nr_ack_wait", 1, 20);
    bus.req = 4'b0;

    // Random traffic
    mem_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      rand_reqs();
    end
    bus.mem_ready = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 200 && !drained; k++) begin
      tick();
      bus.req = bus.req & ~bus.ack;
      if (bus.req == 4'b0 && !bus.mem_req && bus.ack == 4'b0) drained = 1'b1;
    end
    check("drain", 64'(drained), 64'(1));
    mem_mode = 1;
    tick();

    // Timeout
    mem_mode = 2;
    bus.wren = 4'b0;
    bus.addr[3*AW +: AW] = 18'h3FFFF;
    bus.req = 4'b1000;
    wait_sig("to_grant_wait", 0, 20);
    c = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      c++;
      if (bus.ack != 4'b0) break;
    end
    check("to_latency", 64'(c), 64'(16));
    check("to_ack", 64'(bus.ack), 64'(4'b1000));
    check("to_err", 64'(bus.err), 64'(1));
    check("to_rdata", 64'(bus.rdata), 64'(0));
    bus.req = 4'b0;
    tick();
    tick();
    tick();
    check("to_err_sticky", 64'(bus.err), 64'(1));

    // Move ptr off zero
    mem_mode = 1;
    fixed_rd = 32'hCAFEF00D;
    bus.req = 4'b0010;
    wait_sig("p1_grant_wait", 0, 20);
    check("p1_gid", 64'(bus.grant_id), 64'(1));
    wait_sig("p1_ack_wait", 1, 20);
    bus.req = 4'b0;
    tick();

    // Reset mid-BUSY
    mem_mode = 2;
    bus.req = 4'b0100;
    wait_sig("mr_grant_wait", 0, 20);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_mem_req", 64'(bus.mem_req), 64'(0));
    check("mr_ack", 64'(bus.ack), 64'(0));
    check("mr_err", 64'(bus.err), 64'(0));
    check("mr_gid", 64'(bus.grant_id), 64'(0));
    check("mr_addr", 64'(bus.mem_addr), 64'(0));
    bus.req = 4'b0;
    tick();
    rst_n = 1'b1;
    mem_mode = 1;
    bus.req = 4'b1010;
    wait_sig("mr2_grant_wait", 0, 20);
    check("mr_ptr0", 64'(bus.grant_id), 64'(1));
    wait_sig("mr2_ack_wait", 1, 20);
    bus.req = 4'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
